// File: rtl/flip_sequencer_if.sv
// Select handshake from the cursor logic and the card-value store lookup.
// The slave side is the turn sequencer; the master side is the surrounding game logic.
interface flip_sequencer_if #(
    parameter int unsigned VAL_W = 3
);
    logic             sel_valid;
    logic [3:0]       sel_pos;
    logic             sel_ready;
    logic [3:0]       val_addr;
    logic [VAL_W-1:0] val_data;

    modport master (
        output sel_valid, sel_pos, val_data,
        input  sel_ready, val_addr
    );

    modport slave (
        input  sel_valid, sel_pos, val_data,
        output sel_ready, val_addr
    );
endinterface

// File: rtl/flip_sequencer.sv
// Turn controller for the card-flip memory game: flip, compare, reveal, hide or match.
// Optional macro FAST_FLIP_EN: a select during REVEAL ends the reveal and starts a new turn.
module flip_sequencer #(
    parameter int unsigned REVEAL_CYCLES = 50000000,
    parameter int unsigned VAL_W         = 3
) (
    input  logic            clk,
    input  logic            reset,
    input  logic            new_game,
    flip_sequencer_if.slave bus,
    output logic [15:0]     face_up,
    output logic [15:0]     matched,
    output logic [7:0]      move_count,
    output logic            match_pulse,
    output logic            mismatch_pulse,
    output logic            game_won
);
    localparam int unsigned CNT_W = $clog2(REVEAL_CYCLES + 1);

    typedef enum logic [2:0] {
        WAIT_FIRST,
        READ_FIRST,
        WAIT_SECOND,
        READ_SECOND,
        COMPARE,
        REVEAL,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [15:0]      face_up_q, face_up_d;
    logic [15:0]      matched_q, matched_d;
    logic [7:0]       move_count_q, move_count_d;
    logic [3:0]       val_addr_q, val_addr_d;
    logic [3:0]       first_idx_q, first_idx_d;
    logic [3:0]       second_idx_q, second_idx_d;
    logic [VAL_W-1:0] first_val_q, first_val_d;
    logic [VAL_W-1:0] second_val_q, second_val_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             match_pulse_q, match_pulse_d;
    logic             mismatch_pulse_q, mismatch_pulse_d;
    logic             game_won_q, game_won_d;

    logic             sel_ready;
    logic             sel_ok;
    logic [15:0]      sel_bit;
    logic [15:0]      pair_mask;
    logic [15:0]      face_eff;

    assign sel_bit   = 16'd1 << bus.sel_pos;
    assign pair_mask = (16'd1 << first_idx_q) | (16'd1 << second_idx_q);

`ifdef FAST_FLIP_EN
    // In REVEAL the pending pair counts as already hidden, so either card may be re-picked.
    assign sel_ready = (state_q == WAIT_FIRST) || (state_q == WAIT_SECOND) || (state_q == REVEAL);
    assign face_eff  = (state_q == REVEAL) ? (face_up_q & ~pair_mask) : face_up_q;
`else
    assign sel_ready = (state_q == WAIT_FIRST) || (state_q == WAIT_SECOND);
    assign face_eff  = face_up_q;
`endif

    assign sel_ok = bus.sel_valid & sel_ready & ~face_eff[bus.sel_pos];

    always_comb begin
        state_d          = state_q;
        face_up_d        = face_up_q;
        matched_d        = matched_q;
        move_count_d     = move_count_q;
        val_addr_d       = val_addr_q;
        first_idx_d      = first_idx_q;
        second_idx_d     = second_idx_q;
        first_val_d      = first_val_q;
        second_val_d     = second_val_q;
        cnt_d            = cnt_q;
        match_pulse_d    = 1'b0;
        mismatch_pulse_d = 1'b0;
        game_won_d       = game_won_q;

        if (new_game) begin
            state_d      = WAIT_FIRST;
            face_up_d    = '0;
            matched_d    = '0;
            move_count_d = '0;
            val_addr_d   = '0;
            first_idx_d  = '0;
            second_idx_d = '0;
            first_val_d  = '0;
            second_val_d = '0;
            cnt_d        = '0;
            game_won_d   = 1'b0;
        end else begin
            case (state_q)
                WAIT_FIRST: if (sel_ok) begin
                    face_up_d   = face_up_q | sel_bit;
                    val_addr_d  = bus.sel_pos;
                    first_idx_d = bus.sel_pos;
                    state_d     = READ_FIRST;
                end
                READ_FIRST: begin
                    first_val_d = bus.val_data;
                    state_d     = WAIT_SECOND;
                end
                WAIT_SECOND: if (sel_ok) begin
                    face_up_d    = face_up_q | sel_bit;
                    val_addr_d   = bus.sel_pos;
                    second_idx_d = bus.sel_pos;
                    state_d      = READ_SECOND;
                end
                READ_SECOND: begin
                    second_val_d = bus.val_data;
                    state_d      = COMPARE;
                end
                COMPARE: begin
                    if (move_count_q != 8'hFF) move_count_d = move_count_q + 8'd1;
                    if (first_val_q == second_val_q) begin
                        matched_d     = matched_q | pair_mask;
                        match_pulse_d = 1'b1;
                        if (matched_d == 16'hFFFF) begin
                            game_won_d = 1'b1;
                            state_d    = DONE;
                        end else begin
                            state_d = WAIT_FIRST;
                        end
                    end else begin
                        cnt_d   = CNT_W'(REVEAL_CYCLES - 1);
                        state_d = REVEAL;
                    end
                end
                REVEAL: begin
                    if (sel_ok) begin
                        face_up_d        = face_eff | sel_bit;
                        mismatch_pulse_d = 1'b1;
                        val_addr_d       = bus.sel_pos;
                        first_idx_d      = bus.sel_pos;
                        state_d          = READ_FIRST;
                    end else if (cnt_q == '0) begin
                        face_up_d        = face_up_q & ~pair_mask;
                        mismatch_pulse_d = 1'b1;
                        state_d          = WAIT_FIRST;
                    end else begin
                        cnt_d = cnt_q - CNT_W'(1);
                    end
                end
                DONE: ;
                default: state_d = WAIT_FIRST;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q          <= WAIT_FIRST;
            face_up_q        <= '0;
            matched_q        <= '0;
            move_count_q     <= '0;
            val_addr_q       <= '0;
            first_idx_q      <= '0;
            second_idx_q     <= '0;
            first_val_q      <= '0;
            second_val_q     <= '0;
            cnt_q            <= '0;
            match_pulse_q    <= 1'b0;
            mismatch_pulse_q <= 1'b0;
            game_won_q       <= 1'b0;
        end else begin
            state_q          <= state_d;
            face_up_q        <= face_up_d;
            matched_q        <= matched_d;
            move_count_q     <= move_count_d;
            val_addr_q       <= val_addr_d;
            first_idx_q      <= first_idx_d;
            second_idx_q     <= second_idx_d;
            first_val_q      <= first_val_d;
            second_val_q     <= second_val_d;
            cnt_q            <= cnt_d;
            match_pulse_q    <= match_pulse_d;
            mismatch_pulse_q <= mismatch_pulse_d;
            game_won_q       <= game_won_d;
        end
    end

    assign bus.sel_ready  = sel_ready;
    assign bus.val_addr   = val_addr_q;
    assign face_up        = face_up_q;
    assign matched        = matched_q;
    assign move_count     = move_count_q;
    assign match_pulse    = match_pulse_q;
    assign mismatch_pulse = mismatch_pulse_q;
    assign game_won       = game_won_q;
endmodule

// File: tb/tb_flip_sequencer.sv
// Bench for flip_sequencer: directed turn scenarios plus a randomized game scored against a turn-level model.
module tb_flip_sequencer;
    localparam int R = 4;

    logic        clk = 1'b0;
    logic        reset;
    logic        new_game;
    logic [15:0] face_up;
    logic [15:0] matched;
    logic [7:0]  move_count;
    logic        match_pulse;
    logic        mismatch_pulse;
    logic        game_won;
    logic [2:0]  card_val [16];

    int vectors    = 0;
    int miscompares = 0;

    flip_sequencer_if #(.VAL_W(3)) bus ();

    flip_sequencer #(.REVEAL_CYCLES(R), .VAL_W(3)) dut (
        .clk            (clk),
        .reset          (reset),
        .new_game       (new_game),
        .bus            (bus),
        .face_up        (face_up),
        .matched        (matched),
        .move_count     (move_count),
        .match_pulse    (match_pulse),
        .mismatch_pulse (mismatch_pulse),
        .game_won       (game_won)
    );

    always #5 clk = ~clk;

    // Value store answers combinationally from the registered address.
    assign bus.val_data = card_val[bus.val_addr];

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic sel_pulse(input logic [3:0] pos);
        bus.sel_valid = 1'b1;
        bus.sel_pos   = pos;
        tick();
        bus.sel_valid = 1'b0;
    endtask

    task automatic do_new_game();
        new_game      = 1'b1;
        bus.sel_valid = 1'b1;
        bus.sel_pos   = 4'd6;
        tick();
        new_game      = 1'b0;
        bus.sel_valid = 1'b0;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 16; i++) card_val[i] = 3'(i >> 1);
        reset = 1'b0;
        repeat (2) @(negedge clk);
        reset = 1'b1;
        @(negedge clk);
        vectors++;
        if (face_up !== 16'h0 || matched !== 16'h0 || move_count !== 8'd0 || game_won !== 1'b0 ||
            bus.sel_ready !== 1'b1 || bus.val_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_state: face=%h matched=%h moves=%0d won=%b ready=%b addr=%0d, want 0/0/0/0/1/0",
                     face_up, matched, move_count, game_won, bus.sel_ready, bus.val_addr);
        end
        sel_pulse(4'd2);
        tick();
        sel_pulse(4'd5);
        repeat (3) tick();
        vectors++;
        if (face_up !== 16'h0024) begin
            miscompares++;
            $display("FAIL reset_prep_face: got %h want 0024", face_up);
        end
        #2 reset = 1'b0;
        #1;
        vectors++;
        if (face_up !== 16'h0 || matched !== 16'h0 || move_count !== 8'd0 || game_won !== 1'b0 ||
            bus.val_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL reset_async: face=%h matched=%h moves=%0d won=%b addr=%0d, want all 0",
                     face_up, matched, move_count, game_won, bus.val_addr);
        end
        @(negedge clk);
        reset = 1'b1;
        tick();
        vectors++;
        if (bus.sel_ready !== 1'b1 || face_up !== 16'h0) begin
            miscompares++;
            $display("FAIL reset_release: ready=%b face=%h, want 1/0000", bus.sel_ready, face_up);
        end
    endtask

    task automatic test_match();
        sel_pulse(4'd0);
        vectors++;
        if (face_up !== 16'h0001 || bus.sel_ready !== 1'b0 || bus.val_addr !== 4'd0) begin
            miscompares++;
            $display("FAIL match_first: face=%h ready=%b, want 0001/0", face_up, bus.sel_ready);
        end
        tick();
        sel_pulse(4'd1);
        vectors++;
        if (face_up !== 16'h0003 || matched !== 16'h0 || bus.sel_ready !== 1'b0 || bus.val_addr !== 4'd1) begin
            miscompares++;
            $display("FAIL match_second: face=%h matched=%h ready=%b, want 0003/0000/0", face_up, matched, bus.sel_ready);
        end
        tick();
        vectors++;
        if (matched !== 16'h0 || match_pulse !== 1'b0 || bus.sel_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL match_early: matched=%h pulse=%b ready=%b, want 0000/0/0", matched, match_pulse, bus.sel_ready);
        end
        tick();
        vectors++;
        if (matched !== 16'h0003 || face_up !== 16'h0003 || move_count !== 8'd1 || match_pulse !== 1'b1 ||
            bus.sel_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL match_result: matched=%h face=%h moves=%0d pulse=%b ready=%b, want 0003/0003/1/1/1",
                     matched, face_up, move_count, match_pulse, bus.sel_ready);
        end
        tick();
        vectors++;
        if (match_pulse !== 1'b0) begin
            miscompares++;
            $display("FAIL match_pulse_width: got %b want 0", match_pulse);
        end
    endtask

    task automatic test_mismatch();
        int n;
        sel_pulse(4'd2);
        tick();
        sel_pulse(4'd5);
        n = 0;
        while (face_up === 16'h0027 && n < 20) begin
            n++;
`ifndef FAST_FLIP_EN
            if (n == 3) sel_pulse(4'd7);
            else tick();
`else
            tick();
`endif
        end
        vectors++;
        if (n !== 2 + R) begin
            miscompares++;
            $display("FAIL mismatch_visible_cycles: got %0d want %0d", n, 2 + R);
        end
        vectors++;
        if (face_up !== 16'h0003 || mismatch_pulse !== 1'b1 || move_count !== 8'd2 || matched !== 16'h0003) begin
            miscompares++;
            $display("FAIL mismatch_hide: face=%h pulse=%b moves=%0d matched=%h, want 0003/1/2/0003",
                     face_up, mismatch_pulse, move_count, matched);
        end
        tick();
        vectors++;
        if (mismatch_pulse !== 1'b0 || face_up !== 16'h0003 || bus.sel_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL mismatch_after: pulse=%b face=%h ready=%b, want 0/0003/1", mismatch_pulse, face_up, bus.sel_ready);
        end
    endtask

    task automatic test_ineligible();
        sel_pulse(4'd0);
        vectors++;
        if (face_up !== 16'h0003 || bus.sel_ready !== 1'b1 || bus.val_addr !== 4'd5) begin
            miscompares++;
            $display("FAIL inelig_matched: face=%h ready=%b addr=%0d, want 0003/1/5", face_up, bus.sel_ready, bus.val_addr);
        end
        sel_pulse(4'd3);
        tick();
        sel_pulse(4'd3);
        vectors++;
        if (face_up !== 16'h000B || bus.sel_ready !== 1'b1 || move_count !== 8'd2) begin
            miscompares++;
            $display("FAIL inelig_same_card: face=%h ready=%b moves=%0d, want 000b/1/2", face_up, bus.sel_ready, move_count);
        end
        sel_pulse(4'd2);
        tick();
        tick();
        vectors++;
        if (matched !== 16'h000F || move_count !== 8'd3 || match_pulse !== 1'b1) begin
            miscompares++;
            $display("FAIL inelig_then_match: matched=%h moves=%0d pulse=%b, want 000f/3/1", matched, move_count, match_pulse);
        end
    endtask

    task automatic test_win();
        for (int p = 2; p < 8; p++) begin
            sel_pulse(4'(2 * p));
            tick();
            sel_pulse(4'(2 * p + 1));
            tick();
            if (p == 7) begin
                vectors++;
                if (game_won !== 1'b0 || matched !== 16'h3FFF) begin
                    miscompares++;
                    $display("FAIL win_early: won=%b matched=%h, want 0/3fff", game_won, matched);
                end
            end
            tick();
        end
        vectors++;
        if (matched !== 16'hFFFF || game_won !== 1'b1 || move_count !== 8'd9 || bus.sel_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL win_state: matched=%h won=%b moves=%0d ready=%b, want ffff/1/9/0",
                     matched, game_won, move_count, bus.sel_ready);
        end
        sel_pulse(4'd0);
        tick();
        vectors++;
        if (game_won !== 1'b1 || move_count !== 8'd9 || bus.sel_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL win_hold: won=%b moves=%0d ready=%b, want 1/9/0", game_won, move_count, bus.sel_ready);
        end
        do_new_game();
        vectors++;
        if (face_up !== 16'h0 || matched !== 16'h0 || move_count !== 8'd0 || game_won !== 1'b0 || bus.sel_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL new_game_clear: face=%h matched=%h moves=%0d won=%b ready=%b, want 0/0/0/0/1",
                     face_up, matched, move_count, game_won, bus.sel_ready);
        end
        for (int k = 0; k < 256; k++) begin
            sel_pulse(4'd0);
            tick();
            sel_pulse(4'd2);
            repeat (2 + R) tick();
            if (k == 253) begin
                vectors++;
                if (move_count !== 8'd254) begin
                    miscompares++;
                    $display("FAIL sat_before: got %0d want 254", move_count);
                end
            end
        end
        vectors++;
        if (move_count !== 8'd255 || face_up !== 16'h0 || matched !== 16'h0) begin
            miscompares++;
            $display("FAIL sat_hold: moves=%0d face=%h matched=%h, want 255/0000/0000", move_count, face_up, matched);
        end
    endtask

`ifdef FAST_FLIP_EN
    task automatic test_fast_flip();
        do_new_game();
        vectors++;
        if (face_up !== 16'h0 || move_count !== 8'd0) begin
            miscompares++;
            $display("FAIL fast_new_game_priority: face=%h moves=%0d, want 0000/0", face_up, move_count);
        end
        sel_pulse(4'd2);
        tick();
        sel_pulse(4'd5);
        tick();
        tick();
        vectors++;
        if (bus.sel_ready !== 1'b1 || face_up !== 16'h0024) begin
            miscompares++;
            $display("FAIL fast_reveal_ready: ready=%b face=%h, want 1/0024", bus.sel_ready, face_up);
        end
        sel_pulse(4'd4);
        vectors++;
        if (face_up !== 16'h0010 || mismatch_pulse !== 1'b1 || bus.sel_ready !== 1'b0 || bus.val_addr !== 4'd4 ||
            move_count !== 8'd1) begin
            miscompares++;
            $display("FAIL fast_cut: face=%h pulse=%b ready=%b addr=%0d moves=%0d, want 0010/1/0/4/1",
                     face_up, mismatch_pulse, bus.sel_ready, bus.val_addr, move_count);
        end
        tick();
        vectors++;
        if (mismatch_pulse !== 1'b0 || bus.sel_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL fast_after: pulse=%b ready=%b, want 0/1", mismatch_pulse, bus.sel_ready);
        end
        sel_pulse(4'd5);
        tick();
        tick();
        vectors++;
        if (matched !== 16'h0030 || move_count !== 8'd2) begin
            miscompares++;
            $display("FAIL fast_reselect: matched=%h moves=%0d, want 0030/2", matched, move_count);
        end
    endtask
`endif

    task automatic test_random();
        logic [15:0] m_face;
        logic [15:0] m_matched;
        int          m_moves;
        bit          m_pend;
        bit          m_won;
        logic [3:0]  m_first;
        int          won_drops;
        logic [2:0]  t;
        int          j;

        do_new_game();
        for (int i = 0; i < 16; i++) card_val[i] = 3'(i >> 1);
        for (int i = 15; i > 0; i--) begin
            j = int'($urandom_range(i, 0));
            t = card_val[i];
            card_val[i] = card_val[j];
            card_val[j] = t;
        end
        m_face = '0; m_matched = '0; m_moves = 0; m_pend = 0; m_won = 0; m_first = '0; won_drops = 0;

        for (int step = 0; step < 300; step++) begin
            logic [3:0]  pos;
            logic [15:0] pair;
            pos = 4'($urandom_range(15, 0));
            if (m_pend && $urandom_range(1, 0) == 1) begin
                for (int k = 0; k < 16; k++)
                    if (k != int'(m_first) && card_val[k] == card_val[m_first]) pos = 4'(k);
            end
            if (m_won || m_face[pos]) begin
                sel_pulse(pos);
                vectors++;
                if (face_up !== m_face || matched !== m_matched || move_count !== 8'(m_moves) || bus.sel_ready !== !m_won) begin
                    miscompares++;
                    $display("FAIL rnd_drop: pos=%0d face=%h/%h matched=%h/%h moves=%0d/%0d ready=%b/%b",
                             pos, face_up, m_face, matched, m_matched, move_count, m_moves, bus.sel_ready, !m_won);
                end
                if (m_won) won_drops++;
                if (won_drops > 3) break;
            end else if (!m_pend) begin
                m_face[pos] = 1'b1;
                m_pend      = 1'b1;
                m_first     = pos;
                sel_pulse(pos);
                vectors++;
                if (face_up !== m_face || bus.sel_ready !== 1'b0) begin
                    miscompares++;
                    $display("FAIL rnd_first: pos=%0d face=%h/%h ready=%b/0", pos, face_up, m_face, bus.sel_ready);
                end
                tick();
                vectors++;
                if (bus.sel_ready !== 1'b1) begin
                    miscompares++;
                    $display("FAIL rnd_first_ready: got %b want 1", bus.sel_ready);
                end
            end else begin
                pair   = (16'd1 << m_first) | (16'd1 << pos);
                m_face = m_face | pair;
                m_pend = 1'b0;
                if (m_moves < 255) m_moves++;
                sel_pulse(pos);
                vectors++;
                if (face_up !== m_face) begin
                    miscompares++;
                    $display("FAIL rnd_second: pos=%0d face=%h want %h", pos, face_up, m_face);
                end
                tick();
                tick();
                if (card_val[m_first] == card_val[pos]) begin
                    m_matched = m_matched | pair;
                    m_won     = (m_matched == 16'hFFFF);
                    vectors++;
                    if (matched !== m_matched || move_count !== 8'(m_moves) || match_pulse !== 1'b1 ||
                        game_won !== m_won || face_up !== m_face) begin
                        miscompares++;
                        $display("FAIL rnd_match: matched=%h/%h moves=%0d/%0d pulse=%b won=%b/%b face=%h/%h",
                                 matched, m_matched, move_count, m_moves, match_pulse, game_won, m_won, face_up, m_face);
                    end
                    tick();
                    vectors++;
                    if (match_pulse !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rnd_match_pulse: got %b want 0", match_pulse);
                    end
                end else begin
                    vectors++;
                    if (move_count !== 8'(m_moves) || face_up !== m_face || matched !== m_matched || match_pulse !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rnd_reveal: moves=%0d/%0d face=%h/%h matched=%h/%h pulse=%b",
                                 move_count, m_moves, face_up, m_face, matched, m_matched, match_pulse);
                    end
`ifndef FAST_FLIP_EN
                    sel_pulse(4'($urandom_range(15, 0)));
`else
                    tick();
`endif
                    repeat (R - 1) tick();
                    m_face = m_face & ~pair;
                    vectors++;
                    if (face_up !== m_face || mismatch_pulse !== 1'b1 || bus.sel_ready !== 1'b1) begin
                        miscompares++;
                        $display("FAIL rnd_hide: face=%h/%h pulse=%b ready=%b", face_up, m_face, mismatch_pulse, bus.sel_ready);
                    end
                    tick();
                    vectors++;
                    if (mismatch_pulse !== 1'b0) begin
                        miscompares++;
                        $display("FAIL rnd_mismatch_pulse: got %b want 0", mismatch_pulse);
                    end
                end
            end
        end
    endtask

    initial begin
        reset         = 1'b0;
        new_game      = 1'b0;
        bus.sel_valid = 1'b0;
        bus.sel_pos   = '0;
        test_reset();
        test_match();
        test_mismatch();
        test_ineligible();
        test_win();
`ifdef FAST_FLIP_EN
        test_fast_flip();
`endif
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/flip_sequencer.md
Name: flip_sequencer

Overview:
Turn controller for the card-flip memory game. Accepts debounced card selections at the cursor position and looks up card values from the card-value store. Sequences first flip, second flip, compare, timed reveal and hide or match, and maintains the face-up and matched masks, the move counter and the win flag. Sits between cursor/button handling and the display/scoring path.

Parameters:
REVEAL_CYCLES, 50000000, cycles a mismatched pair stays face-up (0.5 s at 100 MHz); legal range >= 1
VAL_W, 3, card value width (8 pairs)

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset (0 = reset)
new_game  in  1  synchronous clear to post-reset state
sel_valid  in  1  one-cycle select request
sel_pos  in  4  card index of request
sel_ready  out  1  sequencer can accept a select this cycle
val_addr  out  4  registered card index presented to value store
val_data  in  VAL_W  value of card at val_addr; valid in the cycle after val_addr updates
face_up  out  16  cards currently shown (matched or under reveal)
matched  out  16  cards permanently matched
move_count  out  8  completed pair attempts, saturating
match_pulse  out  1  one-cycle pulse on a match
mismatch_pulse  out  1  one-cycle pulse when a mismatched pair is hidden
game_won  out  1  all 16 cards matched

Behaviour:
- Reset (async, reset=0): state WAIT_FIRST, face_up=0, matched=0, move_count=0, val_addr=0, all pulses=0, game_won=0. Reset during any state, including REVEAL, takes effect immediately with no clock edge.
- new_game=1 at an edge: same values as reset; has priority over sel_valid.
- States: WAIT_FIRST, READ_FIRST, WAIT_SECOND, READ_SECOND, COMPARE, REVEAL, DONE.
- sel_ready=1 only in WAIT_FIRST and WAIT_SECOND.
- Select eligibility: sel_valid & sel_ready & !face_up[sel_pos]. Ineligible selects are dropped, with no state change and no count change. This covers already-matched cards, the current first card, and selects in other states.
- WAIT_FIRST + eligible select: face_up[sel_pos]<=1, val_addr<=sel_pos, first_idx<=sel_pos; go to READ_FIRST.
- READ_FIRST (1 cycle): first_val<=val_data; go to WAIT_SECOND.
- WAIT_SECOND + eligible select: set face_up bit, val_addr, second_idx; go to READ_SECOND.
- READ_SECOND (1 cycle): second_val<=val_data; go to COMPARE.
- COMPARE (1 cycle):
  - move_count<=move_count+1, saturating at 255.
  - Values equal: set matched bits for both indices and pulse match_pulse. If the updated matched is 16'hFFFF, go to DONE; otherwise go to WAIT_FIRST.
  - Values unequal: load reveal counter with REVEAL_CYCLES-1; go to REVEAL.
- REVEAL: counter decrements each cycle. At 0: clear face_up for both indices, pulse mismatch_pulse, go to WAIT_FIRST. Both cards are visible for exactly REVEAL_CYCLES cycles in REVEAL.
- DONE: game_won=1 (registered, asserted in the cycle matched becomes 16'hFFFF); all selects ignored until new_game or reset.
- Latency: second select accepted at edge E0; match/move_count update visible after E2; game_won visible after E2.
- Counter width is $clog2(REVEAL_CYCLES+1); no wrap (stops at 0).

Optional Feature:
FAST_FLIP_EN
- Defined: sel_ready=1 also in REVEAL. An eligible select in REVEAL ends the reveal in that cycle: both pair bits are cleared, mismatch_pulse fires, and the select is accepted as the first card (its face_up bit is set, go to READ_FIRST). Eligibility is evaluated against face_up with the revealed pair already cleared, so either card of that pair may be re-selected.
- Undefined: REVEAL always runs the full REVEAL_CYCLES and ignores selects.

Test Plan (value store: card i -> value i>>1; REVEAL_CYCLES=4):
1. reset=0 mid-run, no clock -> face_up=0, matched=0, move_count=0, game_won=0; after release sel_ready=1, state WAIT_FIRST.
2. Select 0 then 1 -> matched=16'h0003, face_up=16'h0003, move_count=1, match_pulse high exactly 1 cycle, sel_ready back to 1 two edges after second select.
3. Select 2 then 5 -> face_up=16'h0027 for exactly 4 cycles in REVEAL, then 16'h0003; mismatch_pulse 1 cycle; move_count=2; selects during REVEAL dropped.
4. Select 0 (matched) -> no change. Select 3, select 3 again -> still WAIT_SECOND, face_up bit 3 set, move_count unchanged.
5. Complete all 8 pairs -> game_won=1 in the cycle matched=16'hFFFF. Further selects ignored. new_game -> all cleared. Preload move_count to 255 via 255 attempts -> stays 255.
6. FAST_FLIP_EN: select 2, 5 (mismatch), then select 4 during REVEAL cycle 1 -> bits 2 and 5 cleared, bit 4 set, state READ_FIRST, mismatch_pulse 1 cycle.
